video_palette_mapper: RTL

- Sits directly downstream of the PCW video controller. Consumes its 4-bit colour index, syncs and blanks, and produces 24-bit RGB for the MiSTer video pipeline.
- Mono mode applies a selectable tint. Fake-colour modes look up a CPU-programmable 16-entry RGB444 palette.
- Palette writes land in a shadow bank. The shadow bank is copied into the active bank at the start of vblank, so palette changes never tear mid-frame.

---
 rtl/video_palette_mapper.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/video_palette_mapper.sv
// Maps PCW colour indices to 24-bit RGB: mono tint or 16-entry RGB444 palette.
// Palette writes go to a shadow bank that is committed to the active bank at vblank.
module video_palette_mapper #(
    parameter int unsigned CH_W = 8
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic            ce_pix,
    input  logic [3:0]      colour_in,
    input  logic            hsync_in,
    input  logic            vsync_in,
    input  logic            hb_in,
    input  logic            vb_in,
    input  logic            fake_colour,
    input  logic [1:0]      pcw_video_mode,
    input  logic [1:0]      mono_tint,
    input  logic            pal_wr,
    input  logic [3:0]      pal_idx,
    input  logic [11:0]     pal_data,
    output logic            pal_busy,
    output logic [CH_W-1:0] r,
    output logic [CH_W-1:0] g,
    output logic [CH_W-1:0] b,
    output logic            hsync,
    output logic            vsync,
    output logic            hb,
    output logic            vb,
    output logic            ce_pix_out
);

    localparam int unsigned NUM_ENT = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned PAL_W   = 12;
    localparam int unsigned REP_N   = (CH_W + 3) / 4;
    localparam int unsigned REP_W   = 4 * REP_N;
    localparam int unsigned AMB_W   = (CH_W > 8) ? CH_W : 8;

    // Amber green level is 8'hB0, left-aligned and truncated/zero-padded to CH_W.
    localparam logic [AMB_W-1:0] AMBER_WIDE = AMB_W'(8'hB0) << (AMB_W - 8);
    localparam logic [CH_W-1:0]  AMBER_G    = AMBER_WIDE[AMB_W-1 -: CH_W];

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_COPY = 1'b1
    } state_t;

    function automatic logic [PAL_W-1:0] ega_default(input logic [IDX_W-1:0] idx);
        case (idx)
            4'd0:    return 12'h000;
            4'd1:    return 12'h00A;
            4'd2:    return 12'h0A0;
            4'd3:    return 12'h0AA;
            4'd4:    return 12'hA00;
            4'd5:    return 12'hA0A;
            4'd6:    return 12'hA50;
            4'd7:    return 12'hAAA;
            4'd8:    return 12'h555;
            4'd9:    return 12'h55F;
            4'd10:   return 12'h5F5;
            4'd11:   return 12'h5FF;
            4'd12:   return 12'hF55;
            4'd13:   return 12'hF5F;
            4'd14:   return 12'hFF5;
            default: return 12'hFFF;
        endcase
    endfunction

    // Nibble replicated MSB-first, then truncated to the channel width.
    function automatic logic [CH_W-1:0] expand(input logic [3:0] n);
        logic [REP_W-1:0] rep;
        rep = {REP_N{n}};
        return rep[REP_W-1 -: CH_W];
    endfunction

    logic [PAL_W-1:0] shadow [NUM_ENT];
    logic [PAL_W-1:0] active [NUM_ENT];

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] ptr;
    logic             dirty;
    logic             vb_rise;
    logic             wr_ok;
    logic             commit;
    logic             copy_en;
    logic             busy_nxt;

    logic [IDX_W-1:0] s1_entry;
    logic             s1_fake;
    logic [1:0]       s1_tint;
    logic             s1_c3;
    logic             s1_hs;
    logic             s1_vs;
    logic             s1_hb;
    logic             s1_vb;

    logic [IDX_W-1:0] entry;
    logic [PAL_W-1:0] pal_word;
    logic [CH_W-1:0]  r_nxt;
    logic [CH_W-1:0]  g_nxt;
    logic [CH_W-1:0]  b_nxt;

    assign ce_pix_out = ce_pix;

    // s1_vb holds vb_in from the previous pixel tick, so it doubles as the edge history.
    assign vb_rise = ce_pix & vb_in & ~s1_vb;
    assign wr_ok   = pal_wr & ~pal_busy;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (vb_rise && dirty)            state_nxt = ST_COPY;
            ST_COPY: if (ptr == IDX_W'(NUM_ENT - 1))  state_nxt = ST_IDLE;
            default:                                  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        commit   = 1'b0;
        copy_en  = 1'b0;
        busy_nxt = 1'b0;
        if (state == ST_IDLE && state_nxt == ST_COPY) commit  = 1'b1;
        if (state == ST_COPY)                         copy_en = 1'b1;
        if (state_nxt == ST_COPY)                     busy_nxt = 1'b1;
    end

    // Commit bookkeeping; an accepted write outranks the clear on the commit cycle.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            ptr      <= '0;
            dirty    <= 1'b0;
            pal_busy <= 1'b0;
        end else begin
            pal_busy <= busy_nxt;
            if (commit)       ptr <= '0;
            else if (copy_en) ptr <= ptr + IDX_W'(1);
            if (wr_ok)        dirty <= 1'b1;
            else if (commit)  dirty <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_ENT; i++) shadow[IDX_W'(i)] <= ega_default(IDX_W'(i));
        end else if (wr_ok) begin
            shadow[pal_idx] <= pal_data;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_ENT; i++) active[IDX_W'(i)] <= ega_default(IDX_W'(i));
        end else if (copy_en) begin
            active[ptr] <= shadow[ptr];
        end
    end

    assign entry = (pcw_video_mode == 2'd2) ? colour_in : {2'b00, colour_in[3:2]};

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            s1_entry <= '0;
            s1_fake  <= 1'b0;
            s1_tint  <= 2'd0;
            s1_c3    <= 1'b0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_hb    <= 1'b1;
            s1_vb    <= 1'b1;
        end else if (ce_pix) begin
            s1_entry <= entry;
            s1_fake  <= fake_colour;
            s1_tint  <= mono_tint;
            s1_c3    <= colour_in[3];
            s1_hs    <= hsync_in;
            s1_vs    <= vsync_in;
            s1_hb    <= hb_in;
            s1_vb    <= vb_in;
        end
    end

    assign pal_word = active[s1_entry];

    // Stage-2 colour: blanking forces black, otherwise mono tint or palette lookup.
    always_comb begin
        r_nxt = '0;
        g_nxt = '0;
        b_nxt = '0;
        if (!(s1_hb || s1_vb)) begin
            if (s1_fake) begin
                r_nxt = expand(pal_word[11:8]);
                g_nxt = expand(pal_word[7:4]);
                b_nxt = expand(pal_word[3:0]);
            end else if (s1_c3) begin
                case (s1_tint)
                    2'd1: begin
                        g_nxt = '1;
                    end
                    2'd2: begin
                        r_nxt = '1;
                        g_nxt = AMBER_G;
                    end
                    default: begin
                        r_nxt = '1;
                        g_nxt = '1;
                        b_nxt = '1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r     <= '0;
            g     <= '0;
            b     <= '0;
            hsync <= 1'b0;
            vsync <= 1'b0;
            hb    <= 1'b1;
            vb    <= 1'b1;
        end else if (ce_pix) begin
            r     <= r_nxt;
            g     <= g_nxt;
            b     <= b_nxt;
            hsync <= s1_hs;
            vsync <= s1_vs;
            hb    <= s1_hb;
            vb    <= s1_vb;
        end
    end

endmodule
